// File: rtl/seg7_pair_decoder.sv
// seg7_pair_decoder
//
// Recovers the BCD digits shown on a pair of active-low 7-segment buses.
// This block is the inverse of the BCD-to-7-segment display encoder and sits
// on the display-drive loopback/capture path. The two buses are treated as a
// single 14-bit sample. That sample has to hold for STABLE_CYCLES consecutive
// edges before it is decoded. Each new stable pair is handed out once over a
// valid/ready handshake. Illegal segment patterns are flagged per digit and
// counted in a saturating counter.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg_first    first-digit segment bus, active-low, bit6=g .. bit0=a
//   seg_last     last-digit segment bus, same encoding
//   out_ready    consumer accepts the pair when high together with out_valid
//   out_valid    decoded pair available
//   digit_first  decoded first digit (4'hF blank, 4'hE illegal)
//   digit_last   decoded last digit
//   code_err     {first illegal, last illegal}, qualified by out_valid
//   err_count    delivered pairs containing any illegal code, saturating
//
// State  | meaning
// -------+---------------------------------------------------------------
// S_WAIT | no pair outstanding; deliver when a new sample has become stable
// S_HOLD | pair presented on out_valid; outputs frozen until out_ready

module seg7_pair_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_first,
    input  logic [6:0]       seg_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [3:0]       digit_first,
    output logic [3:0]       digit_last,
    output logic [1:0]       code_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_WAIT = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Returns {illegal, digit}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b1000000: res = 5'h00;
            7'b1111001: res = 5'h01;
            7'b0100100: res = 5'h02;
            7'b0110000: res = 5'h03;
            7'b0011001: res = 5'h04;
            7'b0010010: res = 5'h05;
            7'b0000010: res = 5'h06;
            7'b1111000: res = 5'h07;
            7'b0000000: res = 5'h08;
            7'b0010000: res = 5'h09;
            7'b1111111: res = 5'h0F;
            default:    res = 5'h1E;
        endcase
        return res;
    endfunction

    // Sampler
    logic [13:0]      samp_q, samp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable;
    logic [13:0]      pair_in;

    assign pair_in = {seg_first, seg_last};
    assign stable  = (cnt_q == CNT_MAX);

    always_comb begin
        samp_d = samp_q;
        cnt_d  = cnt_q;
        if (pair_in != samp_q) begin
            samp_d = pair_in;
            cnt_d  = CNT_ONE;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '1;
            cnt_q  <= '0;
        end else begin
            samp_q <= samp_d;
            cnt_q  <= cnt_d;
        end
    end

    // Delivery FSM
    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [3:0]       dfirst_q, dfirst_d;
    logic [3:0]       dlast_q, dlast_d;
    logic [1:0]       cerr_q, cerr_d;
    logic [ERR_W-1:0] errcnt_q, errcnt_d;
    logic [13:0]      last_pair_q, last_pair_d;
    logic             have_last_q, have_last_d;
    logic [4:0]       dec_first, dec_last;
    logic             new_pair;

    assign dec_first = decode_seg(samp_q[13:7]);
    assign dec_last  = decode_seg(samp_q[6:0]);
    // A stable sample equal to the one already delivered is not offered again.
    assign new_pair  = stable && (!have_last_q || (samp_q != last_pair_q));

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dfirst_d    = dfirst_q;
        dlast_d     = dlast_q;
        cerr_d      = cerr_q;
        errcnt_d    = errcnt_q;
        last_pair_d = last_pair_q;
        have_last_d = have_last_q;
        case (state_q)
            S_WAIT: begin
                if (new_pair) begin
                    valid_d     = 1'b1;
                    dfirst_d    = dec_first[3:0];
                    dlast_d     = dec_last[3:0];
                    cerr_d      = {dec_first[4], dec_last[4]};
                    last_pair_d = samp_q;
                    have_last_d = 1'b1;
                    if ((dec_first[4] || dec_last[4]) && (errcnt_q != ERR_MAX)) begin
                        errcnt_d = errcnt_q + ERR_ONE;
                    end
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            valid_q     <= 1'b0;
            dfirst_q    <= 4'h0;
            dlast_q     <= 4'h0;
            cerr_q      <= 2'b00;
            errcnt_q    <= '0;
            last_pair_q <= '0;
            have_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dfirst_q    <= dfirst_d;
            dlast_q     <= dlast_d;
            cerr_q      <= cerr_d;
            errcnt_q    <= errcnt_d;
            last_pair_q <= last_pair_d;
            have_last_q <= have_last_d;
        end
    end

    assign out_valid   = valid_q;
    assign digit_first = dfirst_q;
    assign digit_last  = dlast_q;
    assign code_err    = cerr_q;
    assign err_count   = errcnt_q;

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Bench for seg7_pair_decoder. A run-length reference model predicts every
// output on every cycle. Directed literal checks pin the model itself.
module tb_seg7_pair_decoder;

    localparam int STABLE  = 4;
    localparam int ERR_W   = 8;
    localparam int ERR_MAX = 255;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b1010101;
    localparam logic [6:0] CODES [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       seg_first, seg_last;
    logic             out_ready;
    logic             out_valid;
    logic [3:0]       digit_first, digit_last;
    logic [1:0]       code_err;
    logic [ERR_W-1:0] err_count;

    int n_checks = 0;
    int n_errs   = 0;

    seg7_pair_decoder #(.STABLE_CYCLES(STABLE), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .seg_first(seg_first), .seg_last(seg_last),
        .out_ready(out_ready), .out_valid(out_valid), .digit_first(digit_first),
        .digit_last(digit_last), .code_err(code_err), .err_count(err_count));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {illegal, digit}, obtained by searching the legal code table.
    function automatic logic [4:0] mdec(input logic [6:0] c);
        for (int i = 0; i < 10; i++)
            if (c == CODES[i]) return {1'b0, 4'(i)};
        if (c == BLANK) return 5'h0F;
        return 5'h1E;
    endfunction

    // Reference model: tracks how long the current input value has been held
    // (run length) and which pair was last handed out.
    logic [13:0] run_val, m_last;
    int          run_len;
    logic        m_valid, m_have;
    int          m_df, m_dl, m_ce, m_err;

    always @(posedge clk or negedge rst_n) begin
        logic [13:0] pre;
        logic        pre_stable;
        logic [4:0]  df, dl;
        if (!rst_n) begin
            run_val = 14'h3FFF; run_len = 0;
            m_valid = 0; m_have = 0; m_last = '0;
            m_df = 0; m_dl = 0; m_ce = 0; m_err = 0;
        end else begin
            pre        = run_val;
            pre_stable = (run_len >= STABLE);
            if (m_valid) begin
                if (out_ready) m_valid = 0;
            end else if (pre_stable && (!m_have || pre != m_last)) begin
                df = mdec(pre[13:7]);
                dl = mdec(pre[6:0]);
                m_df = int'(df[3:0]);
                m_dl = int'(dl[3:0]);
                m_ce = int'({df[4], dl[4]});
                if ((df[4] || dl[4]) && m_err < ERR_MAX) m_err++;
                m_valid = 1; m_last = pre; m_have = 1;
            end
            if ({seg_first, seg_last} != run_val) begin
                run_val = {seg_first, seg_last};
                run_len = 1;
            end else if (run_len < 1000) begin
                run_len++;
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("err_count", int'(err_count), m_err);
        if (m_valid) begin
            chk("digit_first", int'(digit_first), m_df);
            chk("digit_last", int'(digit_last), m_dl);
            chk("code_err", int'(code_err), m_ce);
        end
    end

    task automatic drive(input logic [6:0] f, input logic [6:0] l);
        @(negedge clk);
        seg_first = f;
        seg_last  = l;
    endtask

    // Returns the index of the edge after which out_valid was first seen, or -1.
    task automatic wait_valid(input string name, input int max_edges, output int at);
        at = -1;
        for (int i = 0; i < max_edges; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin at = i; break; end
        end
        if (at < 0) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic count_valid(input int edges, output int n);
        n = 0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
    endtask

    initial begin
        int at, n, hold, cap_dl, cap_ce, prev;
        logic [6:0] f, l;
        rst_n = 0; out_ready = 1; seg_first = BLANK; seg_last = BLANK;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_digits", int'({digit_first, digit_last}), 0);
        chk("reset_errcnt", int'(err_count), 0);
        @(negedge clk); rst_n = 1;

        // Blank pair from reset is delivered once.
        wait_valid("blank", 10, at);
        chk("blank_first", int'(digit_first), 15);
        chk("blank_last", int'(digit_last), 15);
        chk("blank_err", int'(code_err), 0);
        count_valid(10, n);
        chk("blank_no_redeliver", n, 0);

        // Latency: the first edge that sees the new value is edge 0.
        drive(CODES[2], CODES[9]);
        wait_valid("latency", 10, at);
        chk("latency_edge", at, STABLE);
        chk("lat_first", int'(digit_first), 2);
        chk("lat_last", int'(digit_last), 9);

        // Sweep every legal code on each bus.
        for (int i = 0; i < 10; i++) begin
            drive(CODES[i], CODES[9-i]);
            repeat (7) @(posedge clk);
        end

        // A glitch shorter than the qualification time is ignored.
        drive(CODES[8], CODES[0]);
        repeat (2) @(posedge clk);
        count_valid(1, n);
        drive(CODES[9], CODES[0]);
        count_valid(10, prev);
        chk("glitch_rejected", n + prev, 0);

        // Back-pressure: outputs frozen while out_ready is low.
        @(negedge clk); out_ready = 0;
        drive(CODES[5], CODES[5]);
        wait_valid("bp_first", 10, at);
        drive(CODES[7], CODES[1]);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_hold_digits", int'({digit_first, digit_last}), 8'h55);
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1;
        chk("bp_handshake_low", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("bp_next_valid", int'(out_valid), 1);
        chk("bp_next_digits", int'({digit_first, digit_last}), 8'h71);

        // Randomized mix of legal, blank and arbitrary codes with random
        // hold lengths and back-pressure.
        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(0, 99);
            f = (n < 60) ? CODES[$urandom_range(0, 9)] : (n < 75) ? BLANK : 7'($urandom_range(0, 127));
            n = $urandom_range(0, 99);
            l = (n < 60) ? CODES[$urandom_range(0, 9)] : (n < 75) ? BLANK : 7'($urandom_range(0, 127));
            drive(f, l);
            out_ready = ($urandom_range(0, 9) < 7);
            repeat ($urandom_range(1, 8)) @(posedge clk);
        end
        @(negedge clk); out_ready = 1;
        repeat (4) @(posedge clk);

        // Illegal last digit on 300 successive distinct pairs: counter saturates.
        prev = -1; cap_dl = -1; cap_ce = -1;
        for (int i = 0; i < 300; i++) begin
            do n = $urandom_range(0, 9); while (n == prev);
            prev = n;
            drive(CODES[n], BAD);
            hold = 5 + $urandom_range(0, 3);
            for (int j = 0; j < hold; j++) begin
                @(posedge clk); #1;
                if (out_valid) begin cap_dl = int'(digit_last); cap_ce = int'(code_err); end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sat_errcnt", int'(err_count), 255);
        chk("sat_digit_last", cap_dl, 14);
        chk("sat_code_err", cap_ce, 1);

        // Reset while holding an undelivered pair.
        @(negedge clk); out_ready = 0;
        drive(CODES[3], CODES[4]);
        wait_valid("rst_hold", 10, at);
        @(negedge clk); #2 rst_n = 0;
        #1;
        chk("rst_async_valid", int'(out_valid), 0);
        chk("rst_async_errcnt", int'(err_count), 0);
        @(negedge clk); @(negedge clk);
        out_ready = 1; rst_n = 1;
        wait_valid("rst_redeliver", 10, at);
        chk("rst_redeliver_edge", at, STABLE);
        chk("rst_redeliver_digits", int'({digit_first, digit_last}), 8'h34);
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
